// File: rtl/flog_ctrl.sv
// Sequencing controller around a bfloat16 natural-log core: screens special operands,
// drives the core for the rest, and holds the result until downstream takes it.
// Optional WAIT watchdog enabled by defining FLOG_TIMEOUT_EN.
module flog_ctrl #(
    parameter int EXP_WIDTH      = 8,
    parameter int FRACT_WIDTH    = 7,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [EXP_WIDTH+FRACT_WIDTH:0] op_i,
    output logic                           core_start_o,
    output logic [15:0]                    core_op_o,
    input  logic                           core_done_i,
    input  logic [15:0]                    core_res_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [15:0]                    res_o,
    output logic                           invalid_o,
    output logic                           divzero_o,
    output logic                           timeout_o
);

    localparam int OPW = 1 + EXP_WIDTH + FRACT_WIDTH;

    typedef enum logic [2:0] {IDLE, CHECK, START, WAIT, DONE} state_t;

    state_t              r_state;
    logic [OPW-1:0]      r_op;
    logic                r_ready;
    logic                r_valid;
    logic                r_start;
    logic [15:0]         r_coreOp;
    logic [15:0]         r_res;
    logic                r_inv;
    logic                r_dz;

    logic                   w_sign;
    logic [EXP_WIDTH-1:0]   w_exp;
    logic [FRACT_WIDTH-1:0] w_fract;
    logic                   w_expOnes;
    logic                   w_expZero;
    logic                   w_fractNz;
    logic                   w_isOne;

    assign w_sign    = r_op[OPW-1];
    assign w_exp     = r_op[EXP_WIDTH+FRACT_WIDTH-1:FRACT_WIDTH];
    assign w_fract   = r_op[FRACT_WIDTH-1:0];
    assign w_expOnes = &w_exp;
    assign w_expZero = ~|w_exp;
    assign w_fractNz = |w_fract;
    assign w_isOne   = (16'(r_op) == 16'h3F80);

`ifdef FLOG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_to;
    assign timeout_o = r_to;
`else
    localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_ready  <= 1'b0;
            r_valid  <= 1'b0;
            r_start  <= 1'b0;
            r_coreOp <= 16'h0000;
            r_res    <= 16'h0000;
            r_inv    <= 1'b0;
            r_dz     <= 1'b0;
`ifdef FLOG_TIMEOUT_EN
            r_cnt    <= '0;
            r_to     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i && r_ready) begin
                        r_op    <= op_i;
                        r_ready <= 1'b0;
                        r_inv   <= 1'b0;
                        r_dz    <= 1'b0;
`ifdef FLOG_TIMEOUT_EN
                        r_to    <= 1'b0;
`endif
                        r_state <= CHECK;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                CHECK: begin
                    r_coreOp <= 16'(r_op);
                    // Priority matters: NaN before zero/inf, sign test only for non-NaN.
                    if (w_expOnes && w_fractNz) begin
                        r_res   <= 16'h7FC0;
                        r_inv   <= ~w_fract[FRACT_WIDTH-1];
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else if (w_expZero) begin
                        r_res   <= 16'hFF80;
                        r_dz    <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else if (w_expOnes && !w_sign) begin
                        r_res   <= 16'h7F80;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else if (w_sign) begin
                        r_res   <= 16'h7FC0;
                        r_inv   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else if (w_isOne) begin
                        r_res   <= 16'h0000;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_start <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    r_start <= 1'b0;
`ifdef FLOG_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A done pulse on the expiry cycle still delivers the core result.
                    if (core_done_i) begin
                        r_res   <= core_res_i;
                        r_inv   <= 1'b0;
                        r_dz    <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
`ifdef FLOG_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_res   <= 16'h7FC0;
                        r_inv   <= 1'b1;
                        r_to    <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o      = r_ready;
    assign valid_o      = r_valid;
    assign core_start_o = r_start;
    assign core_op_o    = r_coreOp;
    assign res_o        = r_res;
    assign invalid_o    = r_inv;
    assign divzero_o    = r_dz;

endmodule

// File: tb/tb_flog_ctrl.sv
// Self-checking bench for flog_ctrl: directed special cases, core handshakes,
// reset abort and randomized operands against a classification model.
module tb_flog_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] op_i;
    logic        core_start_o;
    logic [15:0] core_op_o;
    logic        core_done_i;
    logic [15:0] core_res_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] res_o;
    logic        invalid_o;
    logic        divzero_o;
    logic        timeout_o;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk_i = ~clk_i;

    flog_ctrl #(
        .EXP_WIDTH(8),
        .FRACT_WIDTH(7),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .op_i(op_i),
        .core_start_o(core_start_o),
        .core_op_o(core_op_o),
        .core_done_i(core_done_i),
        .core_res_i(core_res_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .res_o(res_o),
        .invalid_o(invalid_o),
        .divzero_o(divzero_o),
        .timeout_o(timeout_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result of log(x) for the operands the controller answers without the core.
    function automatic void refModel(input logic [15:0] op, output bit special,
                                     output logic [15:0] res, output bit inv, output bit dz);
        int s, e, f;
        s = int'(op) / 32768;
        e = (int'(op) / 128) % 256;
        f = int'(op) % 128;
        special = 1; inv = 0; dz = 0; res = 16'h0000;
        if (e == 255 && f != 0) begin
            res = 16'h7FC0; inv = (f < 64);
        end else if (e == 0) begin
            res = 16'hFF80; dz = 1;
        end else if (e == 255 && s == 0) begin
            res = 16'h7F80;
        end else if (s == 1) begin
            res = 16'h7FC0; inv = 1;
        end else if (op == 16'h3F80) begin
            res = 16'h0000;
        end else begin
            special = 0;
        end
    endfunction

    // coreDelay: cycle (accept = 0) of the core_done pulse; negative = never.
    task automatic applyStimulus(input logic [15:0] op, input int coreDelay,
                                 input logic [15:0] coreRes, input int readyDelay);
        bit          special, inv, dz, to;
        logic [15:0] expRes;
        int          waited, lastWait;
        refModel(op, special, expRes, inv, dz);
        to = 0;
        waited = 0;
        while (ready_o !== 1'b1 && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        checkOutput("ready_before_accept", 32'(ready_o), 32'd1);
        valid_i = 1'b1;
        op_i    = op;
        @(negedge clk_i);
        valid_i = 1'b0;
        op_i    = 16'($urandom);
        checkOutput("ready_low_check", 32'(ready_o), 32'd0);
        checkOutput("valid_low_check", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        if (special) begin
            checkOutput("no_core_start", 32'(core_start_o), 32'd0);
        end else begin
            checkOutput("start_pulse", 32'(core_start_o), 32'd1);
            checkOutput("core_op", 32'(core_op_o), 32'(op));
            checkOutput("valid_low_start", 32'(valid_o), 32'd0);
            lastWait = (coreDelay < 0) ? 18 : coreDelay;
            for (int c = 3; c <= lastWait; c++) begin
                @(negedge clk_i);
                if (c == 3) checkOutput("start_one_cycle", 32'(core_start_o), 32'd0);
                checkOutput("valid_low_wait", 32'(valid_o), 32'd0);
                checkOutput("ready_low_wait", 32'(ready_o), 32'd0);
                if (c == coreDelay) begin
                    core_done_i = 1'b1;
                    core_res_i  = coreRes;
                end
            end
            @(negedge clk_i);
            core_done_i = 1'b0;
            core_res_i  = 16'($urandom);
            if (coreDelay < 0) begin
                expRes = 16'h7FC0; inv = 1; dz = 0; to = 1;
            end else begin
                expRes = coreRes; inv = 0; dz = 0;
            end
            checkOutput("core_op_held", 32'(core_op_o), 32'(op));
        end
        checkOutput("valid_result", 32'(valid_o), 32'd1);
        checkOutput("res", 32'(res_o), 32'(expRes));
        checkOutput("invalid", 32'(invalid_o), 32'(inv));
        checkOutput("divzero", 32'(divzero_o), 32'(dz));
        checkOutput("timeout", 32'(timeout_o), 32'(to));
        for (int k = 0; k < readyDelay; k++) begin
            @(negedge clk_i);
            checkOutput("hold_valid", 32'(valid_o), 32'd1);
            checkOutput("hold_res", 32'(res_o), 32'(expRes));
            checkOutput("hold_ready_low", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        checkOutput("valid_cleared", 32'(valid_o), 32'd0);
        checkOutput("ready_back", 32'(ready_o), 32'd1);
    endtask

    initial begin
        logic [15:0] rop;
        int          cls;
        rst_i       = 1'b1;
        valid_i     = 1'b0;
        op_i        = 16'h0000;
        core_done_i = 1'b0;
        core_res_i  = 16'h0000;
        ready_i     = 1'b0;

        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_ready", 32'(ready_o), 32'd0);
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_start", 32'(core_start_o), 32'd0);
        checkOutput("rst_res", 32'(res_o), 32'd0);
        checkOutput("rst_core_op", 32'(core_op_o), 32'd0);
        checkOutput("rst_flags", 32'({invalid_o, divzero_o, timeout_o}), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("ready_after_rst", 32'(ready_o), 32'd1);

        applyStimulus(16'h3F80, 0, 16'h0, 0);
        applyStimulus(16'h0000, 0, 16'h0, 0);
        applyStimulus(16'h8000, 0, 16'h0, 1);
        applyStimulus(16'h0001, 0, 16'h0, 0);
        applyStimulus(16'h807F, 0, 16'h0, 0);
        applyStimulus(16'hBF80, 0, 16'h0, 0);
        applyStimulus(16'h7F81, 0, 16'h0, 0);
        applyStimulus(16'h7FC1, 0, 16'h0, 2);
        applyStimulus(16'hFF81, 0, 16'h0, 0);
        applyStimulus(16'h7F80, 0, 16'h0, 0);
        applyStimulus(16'hFF80, 0, 16'h0, 0);
        applyStimulus(16'h4000, 7, 16'h3F31, 3);
        applyStimulus(16'h4000, 3, 16'h1234, 0);
        applyStimulus(16'h4000, 18, 16'hBEEF, 0);
`ifdef FLOG_TIMEOUT_EN
        applyStimulus(16'h4000, -1, 16'h0, 1);
`endif

        // Reset mid-WAIT must drop the operation; a late done pulse is ignored.
        valid_i = 1'b1;
        op_i    = 16'h4000;
        @(negedge clk_i);
        valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("abort_start", 32'(core_start_o), 32'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("abort_valid", 32'(valid_o), 32'd0);
        checkOutput("abort_ready_rst", 32'(ready_o), 32'd0);
        checkOutput("abort_res", 32'(res_o), 32'd0);
        core_done_i = 1'b1;
        core_res_i  = 16'h5555;
        @(negedge clk_i);
        core_done_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("abort_no_valid", 32'(valid_o), 32'd0);
            checkOutput("abort_idle_ready", 32'(ready_o), 32'd1);
            @(negedge clk_i);
        end
        applyStimulus(16'h4120, 5, 16'h3C00, 0);

        for (int n = 0; n < 40; n++) begin
            cls = int'($urandom_range(0, 5));
            rop = 16'($urandom);
            case (cls)
                1: rop[14:7] = 8'h00;
                2: rop[14:7] = 8'hFF;
                3: begin rop[15] = 1'b0; if (rop[14:7] == 8'h00 || rop[14:7] == 8'hFF) rop[14:7] = 8'h40; end
                4: rop = 16'h3F80;
                5: begin rop[15] = 1'b1; if (rop[14:7] == 8'h00) rop[14:7] = 8'h81; end
                default: ;
            endcase
            applyStimulus(rop, int'($urandom_range(3, 18)), 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: observed hang expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule

// File: doc/flog_ctrl.md
FLOG_CTRL -- requirements
Module: flog_ctrl

Interface
REQ-001 SHALL have parameters: EXP_WIDTH, default 8, exponent width; FRACT_WIDTH, default 7, mantissa width; TIMEOUT_CYCLES, default 64, maximum core wait in cycles.
REQ-002 SHALL have clock and reset ports: clk_i  in  1  single clock, all logic rising-edge; rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have input handshake ports: valid_i  in  1  operand valid; ready_o  out  1  controller can accept an operand; op_i  in  1+EXP_WIDTH+FRACT_WIDTH  bfloat16 operand {s,exp,fract}.
REQ-004 SHALL have core interface ports: core_start_o  out  1  one-cycle start pulse; core_op_o  out  16  operand to the log core; core_done_i  in  1  core result valid, one-cycle pulse; core_res_i  in  16  core result.
REQ-005 SHALL have output ports: valid_o  out  1  result valid; ready_i  in  1  downstream accepts; res_o  out  16  log result; invalid_o  out  1  NV flag; divzero_o  out  1  DZ flag; timeout_o  out  1  core watchdog fired.

Function
REQ-006 SHALL implement FSM states IDLE, CHECK, START, WAIT, DONE.
REQ-007 IDLE: ready_o=1 only here; valid_i&ready_o registers op_i and moves to CHECK.
REQ-008 CHECK (1 cycle): classify the registered operand; special case moves to DONE with the result loaded; otherwise moves to START.
REQ-009 Special results: any NaN -> 0x7FC0, invalid_o=1 only when SNaN (exp all ones, fract MSB=0, fract nonzero); exp=0 (zero or subnormal, flushed) -> 0xFF80, divzero_o=1; +inf -> 0x7F80; negative nonzero non-NaN (includes -inf) -> 0x7FC0, invalid_o=1; exactly 0x3F80 (+1.0) -> 0x0000.
REQ-010 START: core_start_o=1 for exactly one cycle with core_op_o = registered operand, then WAIT.
REQ-011 WAIT: on core_done_i, capture core_res_i into res_o with all flags 0 and move to DONE; core_done_i in any other state is ignored.
REQ-012 DONE: valid_o=1; res_o and flags held stable until valid_o&ready_i, then IDLE (no same-cycle accept of a new operand).
REQ-013 Latency from accept edge: special case valid_o at cycle 2; normal path core_start_o at cycle 2, valid_o the cycle after core_done_i.
REQ-014 core_op_o SHALL hold the registered operand from CHECK until the next accept.
REQ-015 All outputs SHALL be registered; flags SHALL clear on each accept.

Reset
REQ-016 While rst_i=1 at a clock edge: state=IDLE, ready_o=0 during reset, then 1; valid_o, core_start_o, invalid_o, divzero_o, timeout_o=0; res_o, core_op_o=0x0000; timeout counter=0.
REQ-017 Reset in any state (including WAIT) SHALL abort the operation without emitting a result; a late core_done_i after reset is ignored.

Configuration
REQ-018 Macro FLOG_TIMEOUT_EN SHALL control the WAIT watchdog.
REQ-019 With FLOG_TIMEOUT_EN defined: counter clears on entering WAIT, increments each WAIT cycle; if it reaches TIMEOUT_CYCLES with no core_done_i -> DONE with res_o=0x7FC0, invalid_o=1, timeout_o=1; core_done_i in the same cycle as expiry wins.
REQ-020 Without FLOG_TIMEOUT_EN: no counter; WAIT exits only on core_done_i; timeout_o is tied 0; ports unchanged.

Verification
REQ-021 op_i=0x3F80 accepted -> no core_start_o, valid_o at cycle 2, res_o=0x0000, all flags 0.
REQ-022 op_i=0x0000, then 0x8000, then 0x0001 -> each res_o=0xFF80, divzero_o=1; op_i=0xBF80 -> 0x7FC0, invalid_o=1.
REQ-023 op_i=0x7F81 -> 0x7FC0, invalid_o=1; op_i=0x7FC1 -> 0x7FC0, invalid_o=0; op_i=0x7F80 -> 0x7F80, flags 0.
REQ-024 op_i=0x4000, core_done_i at cycle 7 with core_res_i=0x3F31 -> core_start_o pulse cycle 2 with core_op_o=0x4000, valid_o cycle 8, res_o=0x3F31; ready_i low 3 cycles -> res_o stable, ready_o=0 throughout.
REQ-025 FLOG_TIMEOUT_EN, TIMEOUT_CYCLES=16, op_i=0x4000, no core_done_i -> after 16 WAIT cycles res_o=0x7FC0, invalid_o=1, timeout_o=1.
REQ-026 op_i=0x4000, rst_i=1 for one cycle during WAIT, then core_done_i pulse -> no valid_o, state IDLE, ready_o=1.
